// File: rtl/car_state_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_state_encoder: key sync/debounce + drive-mode FSM -> one-cold state code
// Revision: 1.0
// ---------------------------------------------------------------------------
module car_state_encoder #(
  parameter int DB_CNT       = 500_000,
  parameter int DB_W         = 20,
  parameter int TURN_TIMEOUT = 500_000_000,
  parameter int TO_W         = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] state_out,
  output logic       state_chg,
  output logic       key_reject
);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_GO    = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_BACK  = 3'd4
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);
  localparam bit              TO_EN   = (TURN_TIMEOUT != 0);

  logic [3:0] s1_q, s2_q, db_q, db_prev_q, db_d;
  logic [3:0] press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 4'hF;
      s2_q      <= 4'hF;
      db_q      <= 4'hF;
      db_prev_q <= 4'hF;
    end else begin
      s1_q      <= key_n;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            lvl_d;

    always_comb begin
      cnt_d = '0;
      lvl_d = db_q[i];
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q == DB_LAST) lvl_d = s2_q[i];
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign db_d[i] = lvl_d;
  end

  // Falling debounced level only; releases are not events.
  assign press = db_prev_q & ~db_q;

  function automatic logic [3:0] encode(input state_t s);
    case (s)
      ST_GO:    return 4'b1110;
      ST_LEFT:  return 4'b1101;
      ST_RIGHT: return 4'b1011;
      ST_BACK:  return 4'b0111;
      default:  return 4'b1111;
    endcase
  endfunction

  state_t          state_q, state_d, base_q, base_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      out_q, out_d;
  logic            chg_q, chg_d, rej_q, rej_d;
  logic            in_turn;

  assign in_turn = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rej_d   = 1'b0;
    if ((press & (press - 4'd1)) != 4'd0) begin
      rej_d = 1'b1;
    end else if (press != 4'd0) begin
      // Exactly one event: a press always outranks a pending timeout.
      case (state_q)
        ST_STOP: begin
          if      (press[0]) state_d = ST_GO;
          else if (press[1]) state_d = ST_LEFT;
          else if (press[2]) state_d = ST_RIGHT;
          else               state_d = ST_BACK;
          base_d = ST_STOP;
        end
        ST_GO: begin
          if      (press[0]) state_d = ST_STOP;
          else if (press[1]) state_d = ST_LEFT;
          else if (press[2]) state_d = ST_RIGHT;
          else               rej_d   = 1'b1;
          if (press[1] || press[2]) base_d = ST_GO;
        end
        ST_LEFT: begin
          if      (press[1]) state_d = base_q;
          else if (press[2]) state_d = ST_RIGHT;
          else if (press[0]) state_d = ST_GO;
          else               rej_d   = 1'b1;
        end
        ST_RIGHT: begin
          if      (press[2]) state_d = base_q;
          else if (press[1]) state_d = ST_LEFT;
          else if (press[0]) state_d = ST_GO;
          else               rej_d   = 1'b1;
        end
        ST_BACK: begin
          if (press[3]) state_d = ST_STOP;
          else          rej_d   = 1'b1;
        end
        default: state_d = ST_STOP;
      endcase
    end else if (TO_EN && in_turn && (to_q == TO_LAST)) begin
      state_d = base_q;
    end

    chg_d = (state_d != state_q);
    if (chg_d || !((state_d == ST_LEFT) || (state_d == ST_RIGHT))) to_d = '0;
    else                                                            to_d = to_q + 1'b1;
    out_d = encode(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      base_q  <= ST_STOP;
      to_q    <= '0;
      out_q   <= 4'b1111;
      chg_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      to_q    <= to_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      rej_q   <= rej_d;
    end
  end

  assign state_out  = out_q;
  assign state_chg  = chg_q;
  assign key_reject = rej_q;

endmodule
`default_nettype wire
